// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states and the default operand width.
package mul_div_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    // The encoding puts divide in bit 1 and "unsigned" in bit 0.
    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the register-file read ports, the control
// unit and the writeback path of the multiply/divide unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-cycle multiplier / restoring divider sharing one
// 2*WIDTH+1 accumulator; results are sign-corrected into HI/LO in FIX.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state;
    state_e             next_state;
    op_e                op_q;
    logic [CW-1:0]      count;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_res;
    logic               neg_a;
    logic               dbz_q;

    // Operand conditioning at the start edge.
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    // One iteration of either datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_rem;
    logic               div_fits;

    // Sign-corrected results presented to the HI/LO registers.
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   a_back;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Magnitudes are unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    always_comb begin
        a_neg_in = is_signed_op(bus.op) & bus.a[WIDTH-1];
        b_neg_in = is_signed_op(bus.op) & bus.b[WIDTH-1];
        a_mag_in = a_neg_in ? -bus.a : bus.a;
        b_mag_in = b_neg_in ? -bus.b : bus.b;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a latch.
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (count == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, mag_b});
        div_rem   = div_fits ? (div_shift - {1'b0, mag_b}) : div_shift;
        if (is_div(op_q)) begin
            // Remainder in the upper half, quotient bits shift in at the bottom.
            acc_step = {div_rem, acc[WIDTH-2:0], div_fits};
        end else begin
            // Partial product in the upper half, multiplier bits shift out below.
            acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction
    // ------------------------------------------------------------------
    always_comb begin
        prod_mag = acc[2*WIDTH-1:0];
        prod     = neg_res ? -prod_mag : prod_mag;
        quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        a_back   = neg_a ? -mag_a : mag_a;
        if (dbz_q) begin
            res_hi = a_back;
            res_lo = '1;
        end else if (is_div(op_q)) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q            <= OP_MULT;
            count           <= '0;
            acc             <= '0;
            mag_a           <= '0;
            mag_b           <= '0;
            neg_res         <= 1'b0;
            neg_a           <= 1'b0;
            dbz_q           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.busy <= (next_state != IDLE);
            bus.done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        mag_a   <= a_mag_in;
                        mag_b   <= b_mag_in;
                        neg_a   <= a_neg_in;
                        neg_res <= a_neg_in ^ b_neg_in;
                        dbz_q   <= is_div(bus.op) && (bus.b == '0);
                        count   <= '0;
                        acc     <= {{(WIDTH+1){1'b0}}, is_div(bus.op) ? a_mag_in : b_mag_in};
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    bus.hi          <= res_hi;
                    bus.lo          <= res_lo;
                    bus.div_by_zero <= dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit directly downstream of the register file: it latches the two read-port values (rd1 → a, rd2 → b) on a start strobe and computes a 64-bit product, or a quotient and remainder, over WIDTH cycles. Results land in HI/LO registers that the writeback path reads once done pulses. The control unit stalls issue while busy is high.

## Interface
- WIDTH, 32: operand width; iteration count equals WIDTH.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin an operation; sampled only while busy=0.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  first operand (register file rd1).
- b  in  WIDTH  second operand (register file rd2).
- busy  out  1  operation in progress; reset 0.
- done  out  1  one-cycle pulse when hi/lo are valid; reset 0.
- hi  out  WIDTH  product upper half, or remainder; reset 0.
- lo  out  WIDTH  product lower half, or quotient; reset 0.
- div_by_zero  out  1  valid with done; set for DIV/DIVU with b=0; reset 0.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE: on edge with start=1, latch op, |a| and |b|, result sign bits, and counter=0; go to RUN.
  - RUN: one shift-add (mul) or one restoring subtract-shift (div) step per edge. Counter increments each step; after step WIDTH-1, go to FIX.
  - FIX: apply sign correction, register hi/lo/div_by_zero, pulse done, go to IDLE.
- Magnitudes: signed ops take the two's-complement absolute value; MULTU/DIVU use the raw values. −2^31 is treated as magnitude 2^31, using a WIDTH+1-bit internal magnitude or an unsigned interpretation.
- Signs:
  - MULT: product negated if a[31]^b[31].
  - DIV: quotient negated if a[31]^b[31]; remainder takes the sign of a.
- Division by zero (b=0): full latency still applies. Outputs lo=all-ones, hi=a (original value), div_by_zero=1.
- Signed overflow: DIV of 0x8000_0000 by 0xFFFF_FFFF gives lo=0x8000_0000, hi=0, div_by_zero=0.
- Operands are captured at the start edge; later changes on a/b/op have no effect.
- start while busy=1 is ignored; no queueing.
- hi/lo hold their last value until the next FIX; they are never cleared by a new start.
- Reset mid-operation: the FSM returns to IDLE immediately; busy, done, hi, lo and div_by_zero all go to 0, and the partial result is discarded.

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 from E0.
- Edges E1..E(WIDTH) perform the iterations; state=FIX after E(WIDTH).
- Edge E(WIDTH+1) updates hi/lo; done=1 and busy=0 for exactly the cycle that follows.
- Latency: WIDTH+1 cycles from the start edge to hi/lo valid; 33 for the default.
- Back-to-back: start asserted in the done cycle is accepted at the next edge, so the issue interval is WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU (2-bit);
  - FSM state enum {IDLE, RUN, FIX};
  - default WIDTH constant.
- Single module. The mul and div datapaths share the accumulator (2×WIDTH+1 bits) and the counter, so no sub-module is needed.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → done at 33 cycles; hi=0xFFFF_FFFE, lo=0x0000_0001; busy high for exactly 33 cycles.
- MULT a=0xFFFF_FFFD (−3), b=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (−21).
- DIV a=0xFFFF_FFF9 (−7), b=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1); then DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU a=100, b=0 → lo=0xFFFF_FFFF, hi=100, div_by_zero=1 with done; a following DIVU 100/7 → lo=14, hi=2, div_by_zero=0.
- start pulsed again at cycle 10 of a MULTU 6×7 while busy → ignored; result hi=0, lo=42. start asserted in the done cycle → second op accepted and completes 33 cycles later.
- rst asserted at cycle 15 of a DIV → busy/done/hi/lo/div_by_zero are 0 immediately. No done pulse follows; a new op after reset completes correctly.
